branch_resolve_unit: RTL

//  EXE-side producer for the BTB update interface and the front-end redirect path.

---
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: checks up to two resolved branches per cycle against their BTB
// predictions, issues a registered redirect with a timed flush, and queues taken-branch BTB updates.
// Optional BRU_PERF_CNT_EN adds branch and mispredict performance counters.
module branch_resolve_unit #(
    parameter int UPDQ_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        res0_valid,
    input  logic        res0_taken,
    input  logic [31:0] res0_pc,
    input  logic [31:0] res0_target,
    input  logic        res0_pred_hit,
    input  logic [31:0] res0_pred_target,
    input  logic        res1_valid,
    input  logic        res1_taken,
    input  logic [31:0] res1_pc,
    input  logic [31:0] res1_target,
    input  logic        res1_pred_hit,
    input  logic [31:0] res1_pred_target,
    output logic        stall_o,
    output logic        branch_valid,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [31:0] branch_target_addr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_mispred_cnt,
`endif
    output logic        flush_o
);

    localparam int PTR_W = $clog2(UPDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(UPDQ_DEPTH - 2);
    localparam logic [FC_W-1:0]  FLUSH_LAST  = FC_W'(FLUSH_CYCLES - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state;
    logic [FC_W-1:0]  flush_cnt;

    logic [31:0]      fifo_pc     [UPDQ_DEPTH];
    logic [31:0]      fifo_target [UPDQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             mis0;
    logic             mis1;
    logic             take_redirect;
    logic [31:0]      next_redirect_pc;
    logic             enq0;
    logic             enq1;
    logic             slot1_live;
    logic             pop;
    logic [CNT_W-1:0] n_enq;
    logic [PTR_W-1:0] slot1_ptr;

    assign stall_o = (count > FULL_THRESH) || (state == ST_FLUSH);
    assign accept  = !stall_o && (state == ST_IDLE);

    // A slot mispredicts on a wrong direction or on a taken hit with the wrong target.
    assign mis0 = res0_valid && ((res0_taken != res0_pred_hit) ||
                  (res0_taken && res0_pred_hit && (res0_target != res0_pred_target)));
    assign mis1 = res1_valid && ((res1_taken != res1_pred_hit) ||
                  (res1_taken && res1_pred_hit && (res1_target != res1_pred_target)));

    assign slot1_live    = accept && res1_valid && !mis0;
    assign take_redirect = accept && (mis0 || mis1);

    always_comb begin
        next_redirect_pc = 32'd0;
        if (mis0)
            next_redirect_pc = res0_taken ? res0_target : (res0_pc + 32'd4);
        else if (mis1)
            next_redirect_pc = res1_taken ? res1_target : (res1_pc + 32'd4);
    end

    assign enq0      = accept && res0_valid && res0_taken;
    assign enq1      = slot1_live && res1_taken;
    assign n_enq     = CNT_W'(enq0) + CNT_W'(enq1);
    assign pop       = (count != '0);
    assign slot1_ptr = enq0 ? (wr_ptr + PTR_W'(1)) : wr_ptr;

    always_ff @(posedge clk) begin
        if (enq0) begin
            fifo_pc[wr_ptr]     <= res0_pc;
            fifo_target[wr_ptr] <= res0_target;
        end
        if (enq1) begin
            fifo_pc[slot1_ptr]     <= res1_pc;
            fifo_target[slot1_ptr] <= res1_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_enq);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + n_enq - CNT_W'(pop);
        end
    end

    assign branch_valid       = pop;
    assign branch_taken       = pop;
    assign branch_addr        = pop ? fifo_pc[rd_ptr] : 32'd0;
    assign branch_target_addr = pop ? {fifo_target[rd_ptr][31:1], 1'b0} : 32'd0;

    // The flush counter is loaded on the redirect edge so flush_o covers the redirect cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            redirect_valid <= take_redirect;
            redirect_pc    <= take_redirect ? next_redirect_pc : 32'd0;
            case (state)
                ST_IDLE: begin
                    if (take_redirect) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LAST;
                    end
                end
                default: begin
                    if (flush_cnt == '0)
                        state <= ST_IDLE;
                    else
                        flush_cnt <= flush_cnt - FC_W'(1);
                end
            endcase
        end
    end

    assign flush_o = (state == ST_FLUSH);

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_cnt      <= 32'd0;
            perf_mispred_cnt <= 32'd0;
        end else begin
            perf_br_cnt      <= perf_br_cnt + 32'(accept && res0_valid) + 32'(slot1_live);
            perf_mispred_cnt <= perf_mispred_cnt + 32'(take_redirect);
        end
    end
`endif

endmodule
